// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - cpu_defs: opcodes, ALU codes, state encoding and control word
package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE  = 5'b00000;
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_AND   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;
    localparam logic [4:0] ALU_INCPC = 5'b11111;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
    } state_t;

    // Field order matches the concatenation that drives the interface in the top.
    typedef struct packed {
        logic hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic con_in, mem_read, mem_write;
        logic [4:0] alu_code;
        logic run;
    } ctl_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_defined(input logic [4:0] op);
        return is_alu_op(op) || (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) ||
               (op == OP_ADDI) || (op == OP_BR) || (op == OP_JR) || (op == OP_IN) ||
               (op == OP_OUT) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - datapath/control handshake: status in, strobes out
interface control_unit_if;
    logic [31:0] ir;
    logic        con_ff, mem_ready, stop;
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic Gra, Grb, Grc, RIn, ROut, BAOut;
    logic Conin, memread, memwrite;
    logic [4:0] ALUCode;
    logic run;

    modport master (
        input  ir, con_ff, mem_ready, stop,
        output HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
        output HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
        output Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, ALUCode, run
    );

    modport slave (
        output ir, con_ff, mem_ready, stop,
        input  HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
        input  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
        input  Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, ALUCode, run
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer for the RISC datapath
module control_unit
    import cpu_defs::*;
(
    input  logic            clock,
    input  logic            clear,
    control_unit_if.master  bus
);

    state_t     r_state, w_next;
    logic [4:0] r_opcode_q;
    logic [4:0] w_ir_op;
    logic       w_done;
    ctl_t       w_ctl;

    assign w_ir_op = bus.ir[31:27];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_RESET;
            r_opcode_q <= OP_NOP;
        end else begin
            r_state <= w_next;
            // IR is stable in T3; later states must not see subsequent IR changes
            if (r_state == S_T3)
                r_opcode_q <= w_ir_op;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_RESET: w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    if (bus.mem_ready) w_next = S_T2;
            S_T2: begin
                if (w_ir_op == OP_HALT)         w_next = S_HALT;
                else if (!is_defined(w_ir_op))  w_done = 1'b1;
                else                            w_next = S_T3;
            end
            S_T3: begin
                if (is_alu_op(w_ir_op) || w_ir_op == OP_LD || w_ir_op == OP_LDI ||
                    w_ir_op == OP_ST || w_ir_op == OP_ADDI || w_ir_op == OP_BR)
                    w_next = S_T4;
                else
                    w_done = 1'b1;
            end
            S_T4:    w_next = S_T5;
            S_T5: begin
                if (r_opcode_q == OP_LD || r_opcode_q == OP_ST || r_opcode_q == OP_BR)
                    w_next = S_T6;
                else
                    w_done = 1'b1;
            end
            S_T6: begin
                if (r_opcode_q == OP_ST)                        w_next = S_T7;
                else if (r_opcode_q == OP_LD && bus.mem_ready)  w_next = S_T7;
                else if (r_opcode_q != OP_LD)                   w_done = 1'b1;
            end
            S_T7: begin
                if (r_opcode_q != OP_ST || bus.mem_ready) w_done = 1'b1;
            end
            S_PAUSE: if (!bus.stop) w_next = S_T0;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
        if (w_done)
            w_next = bus.stop ? S_PAUSE : S_T0;
    end

    always_comb begin
        w_ctl = '0;
        if (clear) begin
            case (r_state)
                S_T0: begin
                    w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1; w_ctl.z_in = 1'b1;
                    w_ctl.alu_code = ALU_INCPC;
                end
                S_T1: begin
                    w_ctl.zlo_out = 1'b1; w_ctl.pc_in = 1'b1;
                    w_ctl.mem_read = 1'b1; w_ctl.mdr_in = 1'b1;
                end
                S_T2: begin
                    w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1;
                end
                S_T3: begin
                    if (w_ir_op == OP_LD || w_ir_op == OP_LDI || w_ir_op == OP_ST) begin
                        w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1;
                    end else if (is_alu_op(w_ir_op) || w_ir_op == OP_ADDI) begin
                        w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.y_in = 1'b1;
                    end else if (w_ir_op == OP_BR) begin
                        w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.con_in = 1'b1;
                    end else if (w_ir_op == OP_JR) begin
                        w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.pc_in = 1'b1;
                    end else if (w_ir_op == OP_IN) begin
                        w_ctl.iport_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
                    end else if (w_ir_op == OP_OUT) begin
                        w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.oport_in = 1'b1;
                    end
                end
                S_T4: begin
                    if (is_alu_op(r_opcode_q)) begin
                        w_ctl.grc = 1'b1; w_ctl.r_out = 1'b1; w_ctl.z_in = 1'b1;
                        w_ctl.alu_code = r_opcode_q;
                    end else if (r_opcode_q == OP_BR) begin
                        w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1;
                    end else begin
                        w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_ctl.alu_code = ALU_ADD;
                    end
                end
                S_T5: begin
                    if (r_opcode_q == OP_LD || r_opcode_q == OP_ST) begin
                        w_ctl.zlo_out = 1'b1; w_ctl.mar_in = 1'b1;
                    end else if (r_opcode_q == OP_BR) begin
                        w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; w_ctl.alu_code = ALU_ADD;
                    end else begin
                        w_ctl.zlo_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
                    end
                end
                S_T6: begin
                    if (r_opcode_q == OP_LD) begin
                        w_ctl.mem_read = 1'b1; w_ctl.mdr_in = 1'b1;
                    end else if (r_opcode_q == OP_ST) begin
                        w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.mdr_in = 1'b1;
                    end else if (bus.con_ff) begin
                        w_ctl.zlo_out = 1'b1; w_ctl.pc_in = 1'b1;
                    end
                end
                S_T7: begin
                    if (r_opcode_q == OP_ST) begin
                        w_ctl.mem_write = 1'b1;
                    end else begin
                        w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1;
                    end
                end
                default: w_ctl = '0;
            endcase
            w_ctl.run = (r_state != S_RESET) && (r_state != S_PAUSE) && (r_state != S_HALT);
        end
    end

    assign {bus.HiIn, bus.LoIn, bus.ZIn, bus.PCIn, bus.MDRIn, bus.MARIn, bus.YIn, bus.OPortIn,
            bus.IRIn, bus.HiOut, bus.LoOut, bus.ZHiOut, bus.ZLoOut, bus.PCOut, bus.MDROut,
            bus.IPortOut, bus.COut, bus.Gra, bus.Grb, bus.Grc, bus.RIn, bus.ROut, bus.BAOut,
            bus.Conin, bus.memread, bus.memwrite, bus.ALUCode, bus.run} = w_ctl;

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencing controller for the RISC datapath. It replaces bench-driven control with a cycle-accurate state machine. Each instruction runs as fetch (T0–T2) followed by opcode-specific execute states (T3–T7). In every state the block drives every datapath strobe, the Gra/Grb/Grc register selects, the ALU code and the memory strobes. It also handles memory wait states, pause/halt and reset.

## Interface
Parameters:
- none; opcodes, ALU codes and state encodings are fixed constants in `cpu_defs`.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- clear  in  1  reset, asynchronous and active-low; 0 forces state RESET
- ir  in  32  IR contents from datapath; opcode = ir[31:27]
- con_ff  in  1  CON FF output (datapath ConOut)
- mem_ready  in  1  memory done; 1 completes the current read/write state
- stop  in  1  request pause at next instruction boundary
- HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn  out  1 each  register load enables
- HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut  out  1 each  bus drivers
- Gra, Grb, Grc, RIn, ROut, BAOut  out  1 each  select/encode logic controls
- Conin  out  1  CON FF load
- memread, memwrite  out  1 each  memory strobes
- ALUCode  out  5  ALU operation
- run  out  1  1 while executing; 0 in RESET, PAUSE, HALT

## Operation
- Outputs are Moore-style combinational decode of the registered state and opcode. All outputs are 0 / ALUCode 5'b00000 unless listed. While clear=0, all outputs are 0 and run=0.
- ALU codes: ADD 5'b00011, SUB 5'b00100, AND 5'b00101, OR 5'b00110, INCPC 5'b11111.
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, br 10010, jr 10100, in 10110, out 10111, nop 11010, halt 11011. Undefined opcodes execute as nop.
- Fetch:
  - T0: PCOut MARIn ZIn ALUCode=INCPC.
  - T1: ZLoOut PCIn memread MDRIn; waits for mem_ready.
  - T2: MDROut IRIn.
- ld:
  - T3: Grb BAOut YIn. T4: COut ZIn ALU=ADD. T5: ZLoOut MARIn.
  - T6: memread MDRIn; waits for mem_ready. T7: MDROut Gra RIn.
- ldi:
  - T3/T4 as ld. T5: ZLoOut Gra RIn.
- st:
  - T3–T5 as ld. T6: Gra ROut MDRIn (memread=0 selects bus).
  - T7: memwrite; waits for mem_ready.
- add/sub/and/or:
  - T3: Grb ROut YIn. T4: Grc ROut ZIn ALU=op. T5: ZLoOut Gra RIn.
- addi:
  - T3: Grb ROut YIn. T4: COut ZIn ALU=ADD. T5: ZLoOut Gra RIn.
- br:
  - T3: Gra ROut Conin. T4: PCOut YIn. T5: COut ZIn ALU=ADD.
  - T6: if con_ff=1 then ZLoOut PCIn, else no strobes.
- jr: T3: Gra ROut PCIn.
- in: T3: IPortOut Gra RIn.
- out: T3: Gra ROut OPortIn.
- nop: T2 goes directly to T0.
- halt: T2 goes to HALT. HALT is left only via clear.
- State transitions:
  - RESET → T0 on the first edge with clear=1.
  - Each state lasts one cycle, except wait states.
  - The last execute state → T0, or → PAUSE if stop=1 at that edge.
  - PAUSE → T0 when stop=0.

## Timing
- Opcode timing: T3 decodes ir[31:27] directly, because IR loads at the edge ending T2. opcode_q captures ir[31:27] at the edge leaving T3. T4–T7 decode opcode_q, so later IR changes are ignored.
- Latency with mem_ready=1 throughout:
  - ld 8 cycles; st 8; ldi/ALU/addi 6; br 7; jr/in/out 4; nop 3.
- Wait states: T1, ld-T6 and st-T7 hold their outputs and repeat until mem_ready=1 at a rising edge. mem_ready is ignored in all other states.
- Reset: clear asserted mid-instruction clears outputs immediately. The instruction is abandoned and the PC is not restored.
- stop: only sampled at an instruction boundary, or in PAUSE. stop has no effect in HALT.
- Branch condition: con_ff is used only in br-T6. It reflects the Conin load at the end of T3.

## Structure
- Package `cpu_defs`: opcode constants, ALU codes and the state enum (RESET, T0–T7, PAUSE, HALT, 4-bit encoding).
- Block contents: a single module with a state register, opcode_q, a next-state block and an output decode block. No sub-module.

## Test plan
- **ldi.** Reset, then ldi R2,0x65(R0) with mem_ready=1.
  - Required: T0–T5 strobes exactly as listed; 6 cycles; T5 has ZLoOut, Gra and RIn; run=1.
- **ld with memory wait.** ld with mem_ready low for 2 extra cycles in T6.
  - Required: T6 held 3 cycles with memread and MDRIn steady; then T7 MDROut Gra RIn; total 10 cycles.
- **br.** br with con_ff=0, then br with con_ff=1.
  - Required: in T6, PCIn=0 for the first and ZLoOut+PCIn=1 for the second; T0 follows T6 in both cases.
- **Reset mid-instruction.** Assert clear during add T4.
  - Required: all outputs 0 immediately; RESET; T0 on the first edge after release.
- **stop, then halt.** stop=1 during out T3, then release after 3 cycles; then fetch halt.
  - Required: PAUSE with run=0 for 3 cycles, then T0; after halt, HALT with all outputs 0 and stop ignored.
- **Undefined opcode.** Fetch 11111.
  - Required: T0–T2 only, then T0 (nop behaviour).
